// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Parametrised UART transmitter with a small front-end FIFO. The host pushes
// words; the transmitter pops them and serialises each as one frame:
// start bit (0), DATA_BITS data bits LSB first, an optional parity bit and
// STOP_BITS stop bits (1). Frames go out back-to-back with no idle gap while
// the FIFO holds words. Each bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters
//   DATA_BITS     data bits per frame, 5..9
//   CLKS_PER_BIT  clock cycles per bit period, >= 1
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//   FIFO_DEPTH    words buffered, power of two, >= 2
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   rst         in   synchronous reset, active high; aborts any frame
//   TX_EN       in   write strobe
//   TX_DATA     in   word to send, sampled on the accepting edge
//   TX_READY    out  FIFO not full
//   TX_STATUS   out  1 = transmitter idle (no frame in flight)
//   FIFO_COUNT  out  words waiting in the FIFO (frame in flight excluded)
//   UART_TX     out  serial line, idles high
//   dbg_state   out  current FSM state (0 IDLE, 1 START, 2 DATA, 3 PAR, 4 STOP)
//
// Handshake: a word is accepted on a rising edge where TX_EN && TX_READY.
// TX_READY does not depend on TX_EN, and a full FIFO refuses the write even
// when a pop happens on the same edge (no write-through).
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TX_EN,
  input  logic [DATA_BITS-1:0] TX_DATA,
  output logic                 TX_READY,
  output logic                 TX_STATUS,
  output logic [CNT_W-1:0]     FIFO_COUNT,
  output logic                 UART_TX,
  output logic [2:0]           dbg_state
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_div
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t               state_q, state_n;
  logic [DIV_W-1:0]     div_q, div_n;     // cycle within the current bit
  logic [BIT_W-1:0]     bit_q, bit_n;     // data bit index, or stop bit index
  logic                 div_done;         // last cycle of the current bit

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_q, rd_q;
  logic [CNT_W-1:0]     count_q, count_n;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;
  logic                 fifo_has;

  logic [DATA_BITS-1:0] shift_q, shift_n; // remaining data bits, bit 0 on the line
  logic                 par_q, par_n;     // parity of the frame in flight
  logic                 line_q, line_n;
  logic                 status_q;
  logic                 ready_q;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // ready_q always equals (count_q < FIFO_DEPTH), so it gates the push directly.
  assign push     = TX_EN && ready_q;
  assign fifo_has = (count_q != '0);
  assign head     = mem[rd_q];

  always_comb begin
    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase
  end

  // Storage has no reset: contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= TX_DATA;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      line_q   <= 1'b1;
      status_q <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_n;
      div_q    <= div_n;
      bit_q    <= bit_n;
      count_q  <= count_n;
      shift_q  <= shift_n;
      par_q    <= par_n;
      line_q   <= line_n;
      // Idle is reported once the FSM is headed for IDLE; a pop always moves
      // it to START, so this also means no frame is in flight.
      status_q <= (state_n == S_IDLE);
      ready_q  <= (count_n < DEPTH_C);
      if (push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state, bit timing and pop decision
  // ---------------------------------------------------------------------------
  assign div_done = (div_q == DIV_LAST);

  always_comb begin
    state_n = state_q;
    div_n   = div_q + DIV_W'(1);
    bit_n   = bit_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_n = '0;
        bit_n = '0;
        if (fifo_has) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (div_done) begin
          div_n   = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (div_done) begin
          div_n = '0;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (div_done) begin
          div_n   = '0;
          bit_n   = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (div_done) begin
          div_n = '0;
          if (bit_q == STOP_LAST) begin
            bit_n = '0;
            // Chain straight into the next frame when a word is waiting.
            if (fifo_has) begin
              pop     = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        div_n   = '0;
        bit_n   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: next line value and frame datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    line_n  = line_q;
    shift_n = shift_q;
    par_n   = par_q;
    if (pop) begin
      // Start bit goes out on the same edge the word leaves the FIFO.
      shift_n = head;
      par_n   = (PARITY == 1) ? ~^head : ^head;
      line_n  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          line_n = 1'b1;
        end
        S_START: begin
          if (div_done) begin
            line_n = shift_q[0];
          end
        end
        S_DATA: begin
          if (div_done) begin
            if (bit_q == DATA_LAST) begin
              line_n = (PARITY != 0) ? par_q : 1'b1;
            end else begin
              shift_n = {1'b0, shift_q[DATA_BITS-1:1]};
              line_n  = shift_q[1];
            end
          end
        end
        S_PAR: begin
          if (div_done) begin
            line_n = 1'b1;
          end
        end
        S_STOP: begin
          line_n = 1'b1;
        end
        default: begin
          line_n = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign UART_TX    = line_q;
  assign TX_STATUS  = status_q;
  assign TX_READY   = ready_q;
  assign FIFO_COUNT = count_q;
  assign dbg_state  = state_q;

endmodule
